// File: rtl/game_pkg.sv
// Shared game constants and encodings used by the obstacle scheduler and the
// pixel renderer.
package game_pkg;

  typedef enum logic [1:0] {
    GM_INIT  = 2'b00,
    GM_RUN   = 2'b01,
    GM_PAUSE = 2'b10,
    GM_OVER  = 2'b11
  } gamemode_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H_PX = 480;

  localparam int NUM_SLOTS  = 10;
  localparam int SLOT_IDX_W = 4;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;
  localparam int X_STRIDE   = 20;
  localparam int Y_STRIDE   = 18;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_SPAWN
  } sched_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit left-shifting Fibonacci LFSR (taps 15,13,12,10) that steps only when
// asked, so the sequence is tied to spawn attempts rather than to time.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Owns the obstacle slots: per accepted frame tick it scrolls every active slot
// left, frees those that left the screen, then periodically spawns a new one.
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int          SPEED     = 4,
  parameter int          SPAWN_GAP = 60,
  parameter int          OBS_W     = 40,
  parameter int          SPAWN_X   = 640,
  parameter int          SCREEN_H  = 480,
  parameter int          MIN_H     = 80,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_tick,
  input  logic [1:0]                    gamemode,
  output logic [NUM_SLOTS*X_STRIDE-1:0] obstacle_x,
  output logic [NUM_SLOTS*Y_STRIDE-1:0] obstacle_y,
  output logic [NUM_SLOTS-1:0]          active,
  output logic                          busy,
  output logic                          spawn_drop
);

  localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  localparam logic [X_W-1:0]        SPEED_X   = X_W'(SPEED);
  localparam logic [X_W-1:0]        SPAWN_L   = X_W'(SPAWN_X);
  localparam logic [X_W-1:0]        SPAWN_R   = X_W'(SPAWN_X + OBS_W);
  localparam logic [Y_W-1:0]        BOTTOM_Y  = Y_W'(SCREEN_H);
  localparam logic [Y_W-1:0]        MIN_H_Y   = Y_W'(MIN_H);
  localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(SPAWN_GAP - 1);
  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(NUM_SLOTS - 1);

  sched_state_t            state, state_next;
  logic [SLOT_IDX_W-1:0]   idx, idx_next;
  logic [GAP_W-1:0]        gap_cnt;

  logic [X_W-1:0]          left_q  [NUM_SLOTS];
  logic [X_W-1:0]          right_q [NUM_SLOTS];
  logic [Y_W-1:0]          top_q   [NUM_SLOTS];
  logic [Y_W-1:0]          bot_q   [NUM_SLOTS];

  logic                    clear;
  logic                    spawn_try;
  logic                    full;
  logic [SLOT_IDX_W-1:0]   free_idx;
  logic [15:0]             lfsr;
  logic [Y_W-1:0]          spawn_h, spawn_top, spawn_bot;
  logic                    unused_lfsr_bits;

  // Left edge clamps at the screen edge while the right edge keeps scrolling.
  function automatic logic [X_W-1:0] sat_sub(input logic [X_W-1:0] a);
    return (a >= SPEED_X) ? a - SPEED_X : '0;
  endfunction

  assign clear            = (gamemode == GM_INIT);
  assign unused_lfsr_bits = ^lfsr[15:7];

  lfsr16 #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(spawn_try),
    .state  (lfsr)
  );

  always_comb begin
    state_next = state;
    idx_next   = idx;
    spawn_try  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (frame_tick && gamemode == GM_RUN) begin
          state_next = ST_SCROLL;
          idx_next   = '0;
        end
      end
      ST_SCROLL: begin
        if (idx == LAST_SLOT) state_next = ST_SPAWN;
        else                  idx_next   = idx + SLOT_IDX_W'(1);
      end
      ST_SPAWN: begin
        state_next = ST_IDLE;
        spawn_try  = (gap_cnt == GAP_LAST);
      end
      default: state_next = ST_IDLE;
    endcase
    // Mode 00 overrides whatever the walk was doing.
    if (clear) begin
      state_next = ST_IDLE;
      idx_next   = '0;
      spawn_try  = 1'b0;
    end
  end

  // Lowest-index free slot; slots freed during this frame's scroll count.
  always_comb begin
    free_idx = '0;
    full     = 1'b1;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!active[i]) begin
        free_idx = SLOT_IDX_W'(i);
        full     = 1'b0;
      end
    end
  end

  always_comb begin
    spawn_h   = MIN_H_Y + {{(Y_W-6){1'b0}}, lfsr[5:0]};
    spawn_top = lfsr[6] ? BOTTOM_Y - spawn_h : '0;
    spawn_bot = lfsr[6] ? BOTTOM_Y : spawn_h;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      busy  <= (state_next != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        left_q[i]  <= '0;
        right_q[i] <= '0;
        top_q[i]   <= '0;
        bot_q[i]   <= '0;
      end
      active     <= '0;
      gap_cnt    <= '0;
      spawn_drop <= 1'b0;
    end else begin
      spawn_drop <= spawn_try && full;
      if (state == ST_SCROLL && active[idx]) begin
        if (right_q[idx] <= SPEED_X) begin
          left_q[idx]  <= '0;
          right_q[idx] <= '0;
          top_q[idx]   <= '0;
          bot_q[idx]   <= '0;
          active[idx]  <= 1'b0;
        end else begin
          right_q[idx] <= right_q[idx] - SPEED_X;
          left_q[idx]  <= sat_sub(left_q[idx]);
        end
      end
      if (state == ST_SPAWN) begin
        gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + GAP_W'(1);
      end
      if (spawn_try && !full) begin
        left_q[free_idx]  <= SPAWN_L;
        right_q[free_idx] <= SPAWN_R;
        top_q[free_idx]   <= spawn_top;
        bot_q[free_idx]   <= spawn_bot;
        active[free_idx]  <= 1'b1;
      end
    end
  end

  always_comb begin
    obstacle_x = '0;
    obstacle_y = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      obstacle_x[i*X_STRIDE +: X_W]       = left_q[i];
      obstacle_x[i*X_STRIDE + X_W +: X_W] = right_q[i];
      obstacle_y[i*Y_STRIDE +: Y_W]       = top_q[i];
      obstacle_y[i*Y_STRIDE + Y_W +: Y_W] = bot_q[i];
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench: two scheduler instances, one with default parameters and a
// fast-spawning one for slot-full, mid-walk clear and mid-walk reset cases.
module tb_obstacle_scheduler;

  typedef struct {
    int         slot;
    int         l, r, t, b;
    logic [9:0] act;
    logic       drop;
    int         blen;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick1, tick2;
  logic [1:0]   mode1, mode2;
  logic [199:0] ox1, ox2;
  logic [179:0] oy1, oy2;
  logic [9:0]   act1, act2;
  logic         busy1, busy2, drop1, drop2;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  obstacle_scheduler dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(tick1), .gamemode(mode1),
    .obstacle_x(ox1), .obstacle_y(oy1), .active(act1),
    .busy(busy1), .spawn_drop(drop1)
  );

  obstacle_scheduler #(
    .SPAWN_GAP(1), .SPAWN_X(2), .OBS_W(60)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(tick2), .gamemode(mode2),
    .obstacle_x(ox2), .obstacle_y(oy2), .active(act2),
    .busy(busy2), .spawn_drop(drop2)
  );

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int fx(input logic [199:0] ox, input int i, input int hi);
    return int'(ox[i*20 + hi*10 +: 10]);
  endfunction

  function automatic int fy(input logic [179:0] oy, input int i, input int hi);
    return int'(oy[i*18 + hi*9 +: 9]);
  endfunction

  task automatic check_frame(input string tag, input exp_t e, input logic [199:0] ox,
                             input logic [179:0] oy, input logic [9:0] act,
                             input logic drop, input int blen);
    chk({tag, "_busy_len"}, blen, e.blen);
    chk({tag, "_active"}, int'(act), int'(e.act));
    chk({tag, "_spawn_drop"}, int'(drop), int'(e.drop));
    if (e.slot >= 0) begin
      chk({tag, "_left"},   fx(ox, e.slot, 0), e.l);
      chk({tag, "_right"},  fx(ox, e.slot, 1), e.r);
      chk({tag, "_top"},    fy(oy, e.slot, 0), e.t);
      chk({tag, "_bottom"}, fy(oy, e.slot, 1), e.b);
    end
  endtask

  // Monitors: a completed (or aborted) frame update is signalled by busy falling.
  initial begin
    int   bcnt  = 0;
    logic bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy1 === 1'b1) bcnt++;
      if (bprev && busy1 === 1'b0) begin
        if (q1.size() == 0) chk("dut1_unexpected_frame", bcnt, 0);
        else check_frame("dut1", q1.pop_front(), ox1, oy1, act1, drop1, bcnt);
        bcnt = 0;
      end
      bprev = (busy1 === 1'b1);
    end
  end

  initial begin
    int   bcnt  = 0;
    logic bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy2 === 1'b1) bcnt++;
      if (bprev && busy2 === 1'b0) begin
        if (q2.size() == 0) chk("dut2_unexpected_frame", bcnt, 0);
        else check_frame("dut2", q2.pop_front(), ox2, oy2, act2, drop2, bcnt);
        bcnt = 0;
      end
      bprev = (busy2 === 1'b1);
    end
  end

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic exp_t spawn_exp(input int slot, input logic [15:0] s, input int l,
                                     input int r, input logic [9:0] act, input logic drop);
    exp_t e;
    int   h;
    h      = 80 + int'(s[5:0]);
    e.slot = slot;
    e.l    = l;
    e.r    = r;
    e.t    = s[6] ? 480 - h : 0;
    e.b    = s[6] ? 480 : h;
    e.act  = act;
    e.drop = drop;
    e.blen = 11;
    return e;
  endfunction

  function automatic exp_t plain_exp(input logic [9:0] act, input int blen);
    exp_t e;
    e.slot = -1;
    e.l = 0; e.r = 0; e.t = 0; e.b = 0;
    e.act  = act;
    e.drop = 1'b0;
    e.blen = blen;
    return e;
  endfunction

  function automatic exp_t slot_exp(input int slot, input int l, input int r, input int t,
                                    input int b, input logic [9:0] act);
    exp_t e;
    e = plain_exp(act, 11);
    e.slot = slot;
    e.l = l; e.r = r; e.t = t; e.b = b;
    return e;
  endfunction

  function automatic logic [9:0] act_main(input int f);
    if (f < 60)  return 10'd0;
    if (f < 120) return 10'd1;
    if (f < 180) return 10'd3;
    if (f < 230) return 10'd7;
    if (f < 240) return 10'd6;
    return 10'd7;
  endfunction

  task automatic frame1();
    @(negedge clk); tick1 = 1'b1;
    @(negedge clk); tick1 = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  task automatic frame2();
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    repeat (13) @(negedge clk);
  endtask

  task automatic check_slot0_main(input string tag);
    chk({tag, "_left"},   fx(ox1, 0, 0), 636);
    chk({tag, "_right"},  fx(ox1, 0, 1), 676);
    chk({tag, "_top"},    fy(oy1, 0, 0), 367);
    chk({tag, "_bottom"}, fy(oy1, 0, 1), 480);
    chk({tag, "_active"}, int'(act1), 1);
    chk({tag, "_busy"},   int'(busy1), 0);
  endtask

  initial begin
    logic [15:0] lf;
    exp_t        e;
    rst_n = 1'b0;
    tick1 = 1'b0;
    tick2 = 1'b0;
    mode1 = 2'b01;
    mode2 = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_x",     int'(ox1 != '0), 0);
    chk("reset_y",     int'(oy1 != '0), 0);
    chk("reset_active", int'(act1), 0);
    chk("reset_busy",  int'(busy1), 0);
    chk("reset_drop",  int'(drop1), 0);

    // Main instance: first spawn, scrolling, pause/game-over freeze, exit.
    for (int f = 1; f <= 240; f++) begin
      case (f)
        60:      e = slot_exp(0, 640, 680, 367, 480, act_main(f));
        61:      e = slot_exp(0, 636, 676, 367, 480, act_main(f));
        120:     e = slot_exp(1, 640, 680, 397, 480, act_main(f));
        180:     e = slot_exp(2, 640, 680, 0, 87, act_main(f));
        220:     e = slot_exp(0, 0, 40, 367, 480, act_main(f));
        229:     e = slot_exp(0, 0, 4, 367, 480, act_main(f));
        230:     e = slot_exp(0, 0, 0, 0, 0, act_main(f));
        240:     e = slot_exp(0, 640, 680, 0, 95, act_main(f));
        default: e = plain_exp(act_main(f), 11);
      endcase
      q1.push_back(e);
      frame1();
      if (f == 61) begin
        mode1 = 2'b10;
        repeat (5) frame1();
        check_slot0_main("pause");
        mode1 = 2'b11;
        repeat (5) frame1();
        check_slot0_main("gameover");
        mode1 = 2'b01;
      end
    end

    // Fast instance: fill all slots, overflow, then clear and reset mid-walk.
    mode2 = 2'b01;
    lf = 16'hACE1;
    for (int f = 1; f <= 10; f++) begin
      q2.push_back(spawn_exp(f - 1, lf, 2, 62, 10'((1 << f) - 1), 1'b0));
      lf = lstep(lf);
      frame2();
      if (f == 2) begin
        chk("sat_left",  fx(ox2, 0, 0), 0);
        chk("sat_right", fx(ox2, 0, 1), 58);
      end
    end
    q2.push_back(spawn_exp(0, 16'hACE1, 0, 22, 10'h3FF, 1'b1));
    lf = lstep(lf);
    frame2();
    chk("full_slot9_left",  fx(ox2, 9, 0), 0);
    chk("full_slot9_right", fx(ox2, 9, 1), 58);
    chk("full_drop_after",  int'(drop2), 0);

    q2.push_back(plain_exp(10'd0, 4));
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    repeat (3) @(negedge clk);
    mode2 = 2'b00;
    @(negedge clk);
    chk("clear_x",      int'(ox2 != '0), 0);
    chk("clear_y",      int'(oy2 != '0), 0);
    chk("clear_active", int'(act2), 0);
    chk("clear_busy",   int'(busy2), 0);
    mode2 = 2'b01;
    repeat (8) @(negedge clk);

    q2.push_back(spawn_exp(0, lf, 2, 62, 10'd1, 1'b0));
    lf = lstep(lf);
    frame2();

    q2.push_back(plain_exp(10'd0, 6));
    @(negedge clk); tick2 = 1'b1;
    @(negedge clk); tick2 = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_x",      int'(ox2 != '0), 0);
    chk("rst_active", int'(act2), 0);
    chk("rst_busy",   int'(busy2), 0);
    repeat (7) @(negedge clk);

    q2.push_back(slot_exp(0, 2, 62, 367, 480, 10'd1));
    frame2();

    repeat (5) @(negedge clk);
    chk("q1_left", q1.size(), 0);
    chk("q2_left", q2.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Owns the 10 obstacle slots that the pixel renderer draws. On every frame tick it walks the slots, scrolls each active obstacle left, frees obstacles that have left the screen, and spawns new ones on a fixed frame interval with pseudo-random height and side. It sits between the game logic (`gamemode`, frame timing) and the VGA pixel colour stage, and drives that stage's packed `obstacle_x`/`obstacle_y` buses directly.

## Interface

**Parameters**
- `SPEED`, 4: pixels scrolled left per frame.
- `SPAWN_GAP`, 60: running frames between spawn attempts.
- `OBS_W`, 40: obstacle width in pixels.
- `SPAWN_X`, 640: left edge of a new obstacle.
- `SCREEN_H`, 480: bottom edge of a bottom-attached obstacle.
- `MIN_H`, 80: minimum obstacle height.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. Must be non-zero.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: the single system clock.
- `rst_n`, in, 1: reset. **Synchronous, active-low.**
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blanking.
- `gamemode`, in, 2: 00 = init, 01 = running, 10 = paused, 11 = game over.
- `obstacle_x`, out, 200: per slot i, `[i*20 +: 10]` is the left edge and `[i*20+10 +: 10]` is the right edge (exclusive).
- `obstacle_y`, out, 180: per slot i, `[i*18 +: 9]` is the top edge and `[i*18+9 +: 9]` is the bottom edge (exclusive).
- `active`, out, 10: bit i is set when slot i holds an obstacle.
- `busy`, out, 1: high while a frame update is in progress.
- `spawn_drop`, out, 1: one-cycle pulse when a spawn fails because every slot is full.

## Operation

**Slot encoding**
- A free slot is all zeros (left == right, top == bottom). The renderer skips slots in this state.

**FSM states:** IDLE → SCROLL → SPAWN → IDLE.
- **IDLE**
  - `frame_tick` with `gamemode == 01`: enter SCROLL with the slot index at 0.
  - Ticks in mode 10 or 11 are ignored, so slots freeze.
  - Ticks are also ignored whenever the FSM is not in IDLE.
- **SCROLL**: one slot per cycle, index 0..9. For an active slot:
  - If `right <= SPEED`: free the slot (zero its fields, clear its `active` bit).
  - Otherwise: `right -= SPEED`, and `left = (left >= SPEED) ? left - SPEED : 0` (saturating).
  - Inactive slots are left untouched.
  - After slot 9, go to SPAWN.
- **SPAWN**
  - If `gap_cnt == SPAWN_GAP-1`: set `gap_cnt` to 0 and attempt a spawn. Otherwise increment `gap_cnt`.
  - A spawn fills the lowest-index free slot. Slots freed in the same frame's SCROLL are eligible.
  - If no slot is free: pulse `spawn_drop`; the slots are unchanged.
  - Return to IDLE.
- **Spawned obstacle**
  - Height `h = MIN_H + lfsr[5:0]`.
  - `lfsr[6] == 0`: y = {0, h} (top-attached).
  - `lfsr[6] == 1`: y = {SCREEN_H-h, SCREEN_H} (bottom-attached).
  - x = {SPAWN_X, SPAWN_X+OBS_W}.
  - The LFSR advances exactly once per spawn attempt (including dropped ones), after its value is used.
- **LFSR**
  - 16-bit Fibonacci, shifts left.
  - Feedback bit = `b15 ^ b13 ^ b12 ^ b10`.
- **`gamemode == 00`, in any state**
  - Next cycle: all slots zero, `active` = 0, `gap_cnt` = 0, FSM in IDLE.
  - The LFSR is not reset.
- **Width rules**
  - X arithmetic is 10-bit; `SPAWN_X + OBS_W` must be ≤ 1023.
  - Y arithmetic is 9-bit; `MIN_H + 63` must be ≤ `SCREEN_H`.

## Timing

- **Reset values**: all outputs 0, FSM in IDLE, `gap_cnt` = 0, LFSR = `LFSR_SEED`.
- **Frame update**, for a tick sampled in IDLE at cycle T:
  - Slot k is updated at the clock edge ending cycle T+1+k.
  - The spawn result is registered at the edge ending T+11.
  - `busy` is high during T+1..T+11.
  - `spawn_drop` is high during T+12.
- **Output behaviour**
  - All outputs are registered.
  - Slot fields may change mid-walk; this is acceptable because the walk completes inside vertical blanking.
- **Mode change mid-walk**
  - To 00: the clear overrides the walk.
  - To 10 or 11: the walk still completes. The mode is only sampled at tick acceptance.

## Structure

**Shared package `game_pkg`**
- Gamemode encodings.
- Screen width and height.
- Slot count (10).
- X and Y field widths (10, 9).
- Per-slot packing strides (20, 18).
- The renderer uses the same package.

**Sub-module**
- `lfsr16`: seed parameter, `advance` enable, 16-bit state output.

## Test plan

1. **First spawn.** Reset, `gamemode = 01`, 60 ticks → after the 60th tick's update:
   - slot 0 x = {640, 680}, y = {367, 480} (h = 113, bottom).
   - `active` = 10'b0000000001.
   - `busy` high for exactly 11 cycles.
2. **Scroll.** One more tick → slot 0 x = {636, 676}. Preload a slot with x = {0, 4} and tick → that slot is zeroed and its `active` bit cleared. Preload a slot with x = {2, 30} and tick → x = {0, 26}.
3. **Slot full.** All 10 slots active, spawn frame → `spawn_drop` pulses once at T+12; slots unchanged apart from the scroll; LFSR advanced.
4. **Pause / game over.** `gamemode = 10` or `11`, 5 ticks → outputs bit-identical and `busy` never asserted.
5. **Mode 00 mid-walk.** Set `gamemode = 00` at T+4 → next cycle all outputs 0 and FSM in IDLE. The next running spawn uses the advanced (not reseeded) LFSR value.
6. **Reset mid-walk.** Assert `rst_n = 0` for one clock at T+6 → all outputs and LFSR at their reset values on the following cycle.
